// File: rtl/des_pkg.sv
// Shared DES constants, widths and FSM state type for the S-box feeder.
// Tables hold 1-based DES bit numbers (DES bit 1 = MSB of the vector).
package des_pkg;

    localparam int unsigned R_W   = 32;
    localparam int unsigned K_W   = 48;
    localparam int unsigned GRP_W = 6;
    localparam int unsigned NIB_W = 4;

    localparam int unsigned E_TABLE [K_W] = '{
        32,  1,  2,  3,  4,  5,
         4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13,
        12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21,
        20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29,
        28, 29, 30, 31, 32,  1
    };

    localparam int unsigned P_TABLE [R_W] = '{
        16,  7, 20, 21, 29, 12, 28, 17,
         1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9,
        19, 13, 30,  6, 22, 11,  4, 25
    };

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN,
        DONE
    } fsm_e;

    function automatic logic [R_W-1:0] p_perm(input logic [R_W-1:0] s);
        logic [R_W-1:0] p;
        p = '0;
        for (int i = 0; i < R_W; i++) begin
            p[R_W-1-i] = s[R_W-P_TABLE[i]];
        end
        return p;
    endfunction

endpackage

// File: rtl/des_expand.sv
// Combinational DES E expansion, 32-bit R half to 48 bits.
module des_expand
    import des_pkg::*;
(
    input  logic [R_W-1:0] r_i,
    output logic [K_W-1:0] e_o
);

    always_comb begin
        e_o = '0;
        for (int i = 0; i < K_W; i++) begin
            e_o[K_W-1-i] = r_i[R_W-E_TABLE[i]];
        end
    end

endmodule

// File: rtl/des_sbox_feeder.sv
// Sequential DES f-function front end: serialises E(R)^K to a shared S-box bank.
// Define DES_FEEDER_PPERM_EN to apply the P permutation to f_out.
module des_sbox_feeder
    import des_pkg::*;
#(
    parameter int unsigned PIPE_SBOX = 0,
    parameter int unsigned IDX_W     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [R_W-1:0]   r_half,
    input  logic [K_W-1:0]   subkey,
    output logic [IDX_W-1:0] sbox_idx,
    output logic [GRP_W-1:0] sbox_in,
    input  logic [NIB_W-1:0] sbox_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [R_W-1:0]   f_out
);

    localparam logic [IDX_W-1:0] LAST_IDX = {IDX_W{1'b1}};

    fsm_e             state_q, state_d;
    logic [K_W-1:0]   x_q, x_d;
    logic [K_W-1:0]   e_r, x_new;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] sbox_idx_q, sbox_idx_d;
    logic [GRP_W-1:0] sbox_in_q, sbox_in_d;
    logic [R_W-1:0]   col_q, col_d;
    logic             cap_en;
    logic [IDX_W-1:0] cap_slot;

    des_expand u_expand (
        .r_i (r_half),
        .e_o (e_r)
    );

    assign x_new = e_r ^ subkey;

    function automatic logic [GRP_W-1:0] grp_sel(input logic [K_W-1:0]   x,
                                                 input logic [IDX_W-1:0] k);
        return x[K_W-1-GRP_W*k -: GRP_W];
    endfunction

    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        idx_d      = idx_q;
        sbox_idx_d = sbox_idx_q;
        sbox_in_d  = sbox_in_q;
        col_d      = col_q;
        cap_en     = 1'b0;
        cap_slot   = idx_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Group 0 is presented in the first ISSUE cycle.
                    x_d        = x_new;
                    idx_d      = '0;
                    sbox_idx_d = '0;
                    sbox_in_d  = grp_sel(x_new, '0);
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                if (PIPE_SBOX == 0) begin
                    cap_en   = 1'b1;
                    cap_slot = idx_q;
                end else if (idx_q != '0) begin
                    cap_en   = 1'b1;
                    cap_slot = idx_q - 1'b1;
                end
                if (idx_q == LAST_IDX) begin
                    state_d = (PIPE_SBOX == 0) ? DONE : DRAIN;
                end else begin
                    idx_d      = idx_q + 1'b1;
                    sbox_idx_d = idx_q + 1'b1;
                    sbox_in_d  = grp_sel(x_q, idx_q + 1'b1);
                end
            end
            DRAIN: begin
                cap_en   = 1'b1;
                cap_slot = LAST_IDX;
                state_d  = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (cap_en) begin
            col_d[R_W-1-NIB_W*cap_slot -: NIB_W] = sbox_out;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            x_q        <= '0;
            idx_q      <= '0;
            sbox_idx_q <= '0;
            sbox_in_q  <= '0;
            col_q      <= '0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            idx_q      <= idx_d;
            sbox_idx_q <= sbox_idx_d;
            sbox_in_q  <= sbox_in_d;
            col_q      <= col_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign sbox_idx  = sbox_idx_q;
    assign sbox_in   = sbox_in_q;

`ifdef DES_FEEDER_PPERM_EN
    assign f_out = p_perm(col_q);
`else
    assign f_out = col_q;
`endif

endmodule

// File: tb/tb_des_sbox_feeder.sv
// Scoreboard bench for des_sbox_feeder; runs a combinational and a registered S-box instance.
module tb_des_sbox_feeder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1, sel = 1'b0;
    logic [31:0] r_half = '0;
    logic [47:0] subkey = '0;

    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [2:0]  sbox_idx0, sbox_idx1;
    logic [5:0]  sbox_in0, sbox_in1;
    logic [3:0]  sbox_out0, sbox_out1;
    logic [31:0] f_out0, f_out1;

    logic        in_ready, out_valid;
    logic [2:0]  sbox_idx;
    logic [5:0]  sbox_in;
    logic [31:0] f_out;

    des_sbox_feeder #(.PIPE_SBOX(0), .IDX_W(3)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid & ~sel), .in_ready(in_ready0),
        .r_half(r_half), .subkey(subkey), .sbox_idx(sbox_idx0), .sbox_in(sbox_in0),
        .sbox_out(sbox_out0), .out_valid(out_valid0), .out_ready(out_ready & ~sel),
        .f_out(f_out0)
    );

    des_sbox_feeder #(.PIPE_SBOX(1), .IDX_W(3)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid & sel), .in_ready(in_ready1),
        .r_half(r_half), .subkey(subkey), .sbox_idx(sbox_idx1), .sbox_in(sbox_in1),
        .sbox_out(sbox_out1), .out_valid(out_valid1), .out_ready(out_ready & sel),
        .f_out(f_out1)
    );

    assign in_ready  = sel ? in_ready1  : in_ready0;
    assign out_valid = sel ? out_valid1 : out_valid0;
    assign sbox_idx  = sel ? sbox_idx1  : sbox_idx0;
    assign sbox_in   = sel ? sbox_in1   : sbox_in0;
    assign f_out     = sel ? f_out1     : f_out0;

    // DES S1..S8, each 4 rows of 16.
    int SBOX [512] = '{
        14, 4,13, 1, 2,15,11, 8, 3,10, 6,12, 5, 9, 0, 7,
         0,15, 7, 4,14, 2,13, 1,10, 6,12,11, 9, 5, 3, 8,
         4, 1,14, 8,13, 6, 2,11,15,12, 9, 7, 3,10, 5, 0,
        15,12, 8, 2, 4, 9, 1, 7, 5,11, 3,14,10, 0, 6,13,
        15, 1, 8,14, 6,11, 3, 4, 9, 7, 2,13,12, 0, 5,10,
         3,13, 4, 7,15, 2, 8,14,12, 0, 1,10, 6, 9,11, 5,
         0,14, 7,11,10, 4,13, 1, 5, 8,12, 6, 9, 3, 2,15,
        13, 8,10, 1, 3,15, 4, 2,11, 6, 7,12, 0, 5,14, 9,
        10, 0, 9,14, 6, 3,15, 5, 1,13,12, 7,11, 4, 2, 8,
        13, 7, 0, 9, 3, 4, 6,10, 2, 8, 5,14,12,11,15, 1,
        13, 6, 4, 9, 8,15, 3, 0,11, 1, 2,12, 5,10,14, 7,
         1,10,13, 0, 6, 9, 8, 7, 4,15,14, 3,11, 5, 2,12,
         7,13,14, 3, 0, 6, 9,10, 1, 2, 8, 5,11,12, 4,15,
        13, 8,11, 5, 6,15, 0, 3, 4, 7, 2,12, 1,10,14, 9,
        10, 6, 9, 0,12,11, 7,13,15, 1, 3,14, 5, 2, 8, 4,
         3,15, 0, 6,10, 1,13, 8, 9, 4, 5,11,12, 7, 2,14,
         2,12, 4, 1, 7,10,11, 6, 8, 5, 3,15,13, 0,14, 9,
        14,11, 2,12, 4, 7,13, 1, 5, 0,15,10, 3, 9, 8, 6,
         4, 2, 1,11,10,13, 7, 8,15, 9,12, 5, 6, 3, 0,14,
        11, 8,12, 7, 1,14, 2,13, 6,15, 0, 9,10, 4, 5, 3,
        12, 1,10,15, 9, 2, 6, 8, 0,13, 3, 4,14, 7, 5,11,
        10,15, 4, 2, 7,12, 9, 5, 6, 1,13,14, 0,11, 3, 8,
         9,14,15, 5, 2, 8,12, 3, 7, 0, 4,10, 1,13,11, 6,
         4, 3, 2,12, 9, 5,15,10,11,14, 1, 7, 6, 0, 8,13,
         4,11, 2,14,15, 0, 8,13, 3,12, 9, 7, 5,10, 6, 1,
        13, 0,11, 7, 4, 9, 1,10,14, 3, 5,12, 2,15, 8, 6,
         1, 4,11,13,12, 3, 7,14,10,15, 6, 8, 0, 5, 9, 2,
         6,11,13, 8, 1, 4,10, 7, 9, 5, 0,15,14, 2, 3,12,
        13, 2, 8, 4, 6,15,11, 1,10, 9, 3,14, 5, 0,12, 7,
         1,15,13, 8,10, 3, 7, 4,12, 5, 6,11, 0,14, 9, 2,
         7,11, 4, 1, 9,12,14, 2, 0, 6,10,13,15, 3, 5, 8,
         2, 1,14, 7, 4,10, 8,13,15,12, 9, 0, 3, 5, 6,11
    };

    function automatic logic [3:0] sb(input logic [2:0] idx, input logic [5:0] g);
        int row, col;
        row = {30'd0, g[5], g[0]};
        col = {28'd0, g[4:1]};
        return 4'(SBOX[int'(idx) * 64 + row * 16 + col]);
    endfunction

    always_comb sbox_out0 = sb(sbox_idx0, sbox_in0);
    always_ff @(posedge clk) sbox_out1 <= sb(sbox_idx1, sbox_in1);

`ifdef DES_FEEDER_PPERM_EN
    localparam logic [31:0] F_FIPS = 32'h234AA9BB;
    localparam logic [31:0] F_ZERO = 32'hD8D8DBBC;
`else
    localparam logic [31:0] F_FIPS = 32'h5C82B597;
    localparam logic [31:0] F_ZERO = 32'hEFA72C4D;
`endif
    localparam logic [31:0] R_FIPS = 32'hF0AAF0AA;
    localparam logic [47:0] K_FIPS = 48'h1B02EFFC7072;
    localparam logic [47:0] X_FIPS = 48'h6117BA866527;

    int          n_tests = 0, n_fail = 0, cyc = 0;
    logic [31:0] exp_q [$];
    int          hs_q [$];
    logic        ov_prev = 1'b0;
    logic        b2b = 1'b0;
    int          b2b_hs = 0, last_ohs = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: latency on out_valid rise, result compare on output handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) begin
                hs_q.push_back(cyc);
                if (b2b) begin
                    b2b_hs++;
                    if (b2b_hs == 2) chk("b2b_ready_cycle", 64'(cyc), 64'(last_ohs + 1));
                end
            end
            if (out_valid && !ov_prev) begin
                if (hs_q.size() == 0) begin
                    chk("valid_without_input", 64'(out_valid), 64'd0);
                end else begin
                    chk("latency", 64'(cyc - hs_q.pop_front()), sel ? 64'd10 : 64'd9);
                end
            end
            if (out_valid && out_ready) begin
                last_ohs = cyc;
                if (exp_q.size() == 0) chk("unexpected_output", 64'(f_out), 64'hFFFF_FFFF_FFFF);
                else chk("f_out", 64'(f_out), 64'(exp_q.pop_front()));
            end
            ov_prev = out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        hs_q.delete();
    endtask

    task automatic send(input logic [31:0] r, input logic [47:0] k, input logic [31:0] f);
        bit ok = 1'b0;
        in_valid = 1'b1;
        r_half   = r;
        subkey   = k;
        exp_q.push_back(f);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (!ok) chk("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic check_issue(input string tag, input logic [47:0] x);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk({tag, "_sbox_idx"}, 64'(sbox_idx), 64'(k));
            chk({tag, "_sbox_in"}, 64'(sbox_in), 64'(x[47-6*k -: 6]));
        end
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (out_valid) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (!ok) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            out_ready = 1'b1;
            do_reset();
            @(negedge clk);
            chk("rst_in_ready", 64'(in_ready), 64'd1);
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_sbox_idx", 64'(sbox_idx), 64'd0);
            chk("rst_sbox_in", 64'(sbox_in), 64'd0);
            chk("rst_f_out", 64'(f_out), 64'd0);
            @(posedge clk);
            #1;

            // FIPS round-1 vector
            send(R_FIPS, K_FIPS, F_FIPS);
            check_issue("fips", X_FIPS);
            wait_done();

            // Zero operands under backpressure; busy-time in_valid pulses must be ignored
            out_ready = 1'b0;
            send(32'h0, 48'h0, F_ZERO);
            check_issue("zero", 48'h0);
            wait_done();
            for (int i = 0; i < 5; i++) begin
                in_valid = (i % 2 == 0);
                r_half   = 32'h1234_5678 + i;
                @(negedge clk);
                chk("stall_out_valid", 64'(out_valid), 64'd1);
                chk("stall_in_ready", 64'(in_ready), 64'd0);
                chk("stall_f_out", 64'(f_out), 64'(F_ZERO));
                @(posedge clk);
                #1;
            end
            in_valid  = 1'b0;
            out_ready = 1'b1;
            repeat (12) @(posedge clk);
            #1;
            @(negedge clk);
            chk("post_stall_idle", 64'({in_ready, out_valid}), 64'b10);
            @(posedge clk);
            #1;

            // Reset while issuing group 4
            send(R_FIPS, K_FIPS, F_FIPS);
            repeat (4) @(posedge clk);
            #1;
            @(negedge clk);
            chk("abort_at_idx", 64'(sbox_idx), 64'd4);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            exp_q.delete();
            hs_q.delete();
            @(negedge clk);
            chk("abort_in_ready", 64'(in_ready), 64'd1);
            chk("abort_out_valid", 64'(out_valid), 64'd0);
            chk("abort_f_out", 64'(f_out), 64'd0);
            @(posedge clk);
            #1;
            send(R_FIPS, K_FIPS, F_FIPS);
            wait_done();

            // Back-to-back operand pairs with out_ready held high
            b2b    = 1'b1;
            b2b_hs = 0;
            send(R_FIPS, K_FIPS, F_FIPS);
            send(32'h0, 48'h0, F_ZERO);
            wait_done();
            b2b = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk("b2b_handshakes", 64'(b2b_hs), 64'd2);
            chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
